// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine.
//   - FSM state encoding (IDLE / CALC / COMMIT)
//   - popcount(): elaboration-time population count of a seed board
//   - idx(): row/col to flat cell index (cell = row*W + col)
//   - GLIDER_SEED_8X8: default seed for the 8x8 top level
package life_pkg;

    // Largest board popcount() can inspect (BIT_W + BIT_H <= 12).
    localparam int MAX_CELLS = 4096;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t CALC   = 2'd1;
    localparam state_t COMMIT = 2'd2;

    // Glider at the top-left corner: cells (0,1) (1,2) (2,0) (2,1) (2,2).
    localparam logic [63:0] GLIDER_SEED_8X8 = 64'h0000_0000_0007_0402;

    function automatic int unsigned popcount(input logic [MAX_CELLS-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int k = 0; k < MAX_CELLS; k++) begin
            cnt += 32'(v[k]);
        end
        return cnt;
    endfunction

    function automatic int unsigned idx(input int unsigned row,
                                        input int unsigned col,
                                        input int unsigned bit_w);
        return (row << bit_w) | col;
    endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// Combinational count of the eight live neighbours of cell i.
//   cur    : committed board, bit k = cell k = row*W + col
//   i      : index of the cell being evaluated
//   wrap_q : 1 = toroidal edges, 0 = cells outside the board read as dead
//   n      : number of live neighbours, 0..8
module life_neighbour_count #(
    parameter int BIT_W = 3,
    parameter int BIT_H = 3
) (
    input  logic [(2**(BIT_W+BIT_H))-1:0] cur,
    input  logic [BIT_W+BIT_H-1:0]        i,
    input  logic                          wrap_q,
    output logic [3:0]                    n
);

    logic [BIT_H-1:0] row;
    logic [BIT_W-1:0] col;
    logic [BIT_H-1:0] r [3];
    logic [BIT_W-1:0] c [3];
    logic             r_ok [3];
    logic             c_ok [3];

    always_comb begin
        // NOTE: every output of this block is assigned before any conditional
        // use, so no path leaves a value held and no latch is inferred.
        n   = '0;
        row = i[BIT_W+BIT_H-1:BIT_W];
        col = i[BIT_W-1:0];

        // Natural bit-width overflow gives the modulo-W/H torus for free.
        r[0] = row - BIT_H'(1);
        r[1] = row;
        r[2] = row + BIT_H'(1);
        c[0] = col - BIT_W'(1);
        c[1] = col;
        c[2] = col + BIT_W'(1);

        // Without wrap, a step off the first/last row or column is dead.
        r_ok[0] = wrap_q | (row != '0);
        r_ok[1] = 1'b1;
        r_ok[2] = wrap_q | (row != '1);
        c_ok[0] = wrap_q | (col != '0);
        c_ok[1] = 1'b1;
        c_ok[2] = wrap_q | (col != '1);

        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1) && r_ok[dr] && c_ok[dc]) begin
                    n = n + 4'(cur[{r[dr], c[dc]}]);
                end
            end
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: W x H board, one generation per trigger, one cell per
// clock into a shadow board, committed atomically in a single cycle.
//   clk, reset            : pixel clock, synchronous active-high reset
//   run, frame_tick       : with run high, each frame_tick starts a generation
//   step                  : pulse, starts a generation regardless of run
//   wrap_en               : toroidal edges, sampled when a generation starts
//   load_en/addr/data     : write one committed cell (idle only)
//   clear                 : zero the committed board (idle only, beats load)
//   rd_addr / rd_data     : combinational display read of the committed board
//   busy                  : generation in progress (CALC or COMMIT)
//   gen_count             : generations committed since reset
//   alive_count           : population of the committed board
//   stable                : last commit left the board unchanged
module life_engine
    import life_pkg::*;
#(
    parameter int BIT_W = 3,
    parameter int BIT_H = 3,
    parameter logic [(2**(BIT_W+BIT_H))-1:0] SEED =
        (2**(BIT_W+BIT_H))'(GLIDER_SEED_8X8),
    parameter int GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   frame_tick,
    input  logic                   wrap_en,
    input  logic                   load_en,
    input  logic [BIT_W+BIT_H-1:0] load_addr,
    input  logic                   load_data,
    input  logic                   clear,
    input  logic [BIT_W+BIT_H-1:0] rd_addr,
    output logic                   rd_data,
    output logic                   busy,
    output logic [GEN_W-1:0]       gen_count,
    output logic [BIT_W+BIT_H:0]   alive_count,
    output logic                   stable
);

    localparam int ADDR_W = BIT_W + BIT_H;
    localparam int SIZE   = 2**ADDR_W;
    localparam logic [ADDR_W:0] SEED_POP =
        (ADDR_W+1)'(popcount(MAX_CELLS'(SEED)));

    logic [SIZE-1:0]   cur;
    logic [SIZE-1:0]   nxt;
    state_t            state;
    logic [ADDR_W-1:0] i;
    logic              wrap_q;
    logic [ADDR_W:0]   pop;
    logic              diff;
    logic [3:0]        n;
    logic              next_cell;
    logic              trig;

    assign trig      = step | (run & frame_tick);
    assign next_cell = (n == 4'd3) | (cur[i] & (n == 4'd2));
    assign rd_data   = cur[rd_addr];
    assign busy      = (state != IDLE);

    life_neighbour_count #(
        .BIT_W (BIT_W),
        .BIT_H (BIT_H)
    ) u_count (
        .cur    (cur),
        .i      (i),
        .wrap_q (wrap_q),
        .n      (n)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: both boards are plain flop vectors, so resetting them is
            // legal and cheap; a RAM-based board could not be reset this way.
            cur         <= SEED;
            nxt         <= '0;
            state       <= IDLE;
            i           <= '0;
            wrap_q      <= 1'b0;
            pop         <= '0;
            diff        <= 1'b0;
            gen_count   <= '0;
            alive_count <= SEED_POP;
            stable      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state  <= CALC;
                        i      <= '0;
                        wrap_q <= wrap_en;
                        pop    <= '0;
                        diff   <= 1'b0;
                    end else if (clear) begin
                        cur         <= '0;
                        alive_count <= '0;
                    end else if (load_en) begin
                        cur[load_addr] <= load_data;
                        if (load_data && !cur[load_addr]) begin
                            alive_count <= alive_count + (ADDR_W+1)'(1);
                        end else if (!load_data && cur[load_addr]) begin
                            alive_count <= alive_count - (ADDR_W+1)'(1);
                        end
                    end
                end
                CALC: begin
                    nxt[i] <= next_cell;
                    pop    <= pop + (ADDR_W+1)'(next_cell);
                    diff   <= diff | (next_cell ^ cur[i]);
                    // The last cell index is all ones.
                    if (&i) begin
                        state <= COMMIT;
                    end else begin
                        i <= i + ADDR_W'(1);
                    end
                end
                COMMIT: begin
                    cur         <= nxt;
                    alive_count <= pop;
                    stable      <= ~diff;
                    gen_count   <= gen_count + GEN_W'(1);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
`timescale 1ns/10ps
// Directed bench for life_engine: 8x8 instance seeded with a blinker plus a
// 16x8 instance running the same blinker pattern.
module tb_life_engine;
    import life_pkg::*;

    localparam int SIZE = 64;
    localparam logic [63:0]  BLINKER   = 64'h0000_0000_3800_0000;                      // 27,28,29
    localparam logic [127:0] BLINKER16 = 128'h0000_0000_0000_0000_0070_0000_0000_0000; // 52,53,54

    logic        clk = 1'b0;
    logic        reset, run, step, frame_tick, wrap_en, load_en, load_data, clear;
    logic [5:0]  load_addr, rd_addr;
    logic        rd_data, busy, stable;
    logic [15:0] gen_count;
    logic [6:0]  alive_count;

    logic        step2;
    logic [6:0]  rd_addr2;
    logic        rd_data2, busy2, stable2;
    logic [15:0] gen_count2;
    logic [7:0]  alive_count2;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0]  board;
    logic [127:0] board16;

    always #5 clk = ~clk;

    life_engine #(.BIT_W(3), .BIT_H(3), .SEED(BLINKER), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .frame_tick(frame_tick),
        .wrap_en(wrap_en), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .gen_count(gen_count), .alive_count(alive_count), .stable(stable)
    );

    life_engine #(.BIT_W(4), .BIT_H(3), .SEED(BLINKER16), .GEN_W(16)) dut16 (
        .clk(clk), .reset(reset), .run(1'b0), .step(step2), .frame_tick(1'b0),
        .wrap_en(wrap_en), .load_en(1'b0), .load_addr(7'd0),
        .load_data(1'b0), .clear(1'b0), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .busy(busy2), .gen_count(gen_count2), .alive_count(alive_count2), .stable(stable2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] cells(input int a, input int b, input int c,
                                          input int d, input int e);
        logic [63:0] v;
        int l [5];
        v = '0;
        l = '{a, b, c, d, e};
        foreach (l[k]) if (l[k] >= 0) v[l[k]] = 1'b1;
        return v;
    endfunction

    // Whole-board reads stay inside one clock low/high window.
    task automatic get_board(output logic [63:0] b);
        for (int k = 0; k < 64; k++) begin
            rd_addr = 6'(k);
            #0.1;
            b[k] = rd_data;
        end
    endtask

    task automatic get_board16(output logic [127:0] b);
        for (int k = 0; k < 128; k++) begin
            rd_addr2 = 7'(k);
            #0.05;
            b[k] = rd_data2;
        end
    endtask

    task automatic load_cell(input int a, input logic d);
        load_en = 1'b1; load_addr = 6'(a); load_data = d;
        tick;
        load_en = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    task automatic pulse_step;
        step = 1'b1;
        tick;
        step = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            tick;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; frame_tick = 1'b0; wrap_en = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = 1'b0; clear = 1'b0;
        rd_addr = '0; step2 = 1'b0; rd_addr2 = '0;
        repeat (3) tick;
        reset = 1'b0;

        // Reset state
        get_board(board);
        check("reset_board", board, BLINKER);
        check("reset_gen", gen_count, 0);
        check("reset_alive", alive_count, 3);
        check("reset_stable", stable, 0);
        check("reset_busy", busy, 0);

        // 16x8 blinker
        step2 = 1'b1; tick; step2 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!busy2) break;
            tick;
        end
        check("b16_idle", busy2, 0);
        get_board16(board16);
        check("b16_board", board16, (128'd1 << 37) | (128'd1 << 53) | (128'd1 << 69));
        check("b16_gen", gen_count2, 1);
        check("b16_alive", alive_count2, 3);

        // Blinker with exact latency
        step = 1'b1; tick; step = 1'b0;
        check("lat_busy_first", busy, 1);
        repeat (SIZE) tick;
        check("lat_busy_commit", busy, 1);
        rd_addr = 6'd20; #0.1;
        check("lat_old_board", rd_data, 0);
        tick;
        check("lat_busy_done", busy, 0);
        get_board(board);
        check("blink1_board", board, cells(20, 28, 36, -1, -1));
        check("blink1_gen", gen_count, 1);
        check("blink1_alive", alive_count, 3);
        check("blink1_stable", stable, 0);
        pulse_step;
        wait_idle("blink2_idle");
        get_board(board);
        check("blink2_board", board, BLINKER);
        check("blink2_gen", gen_count, 2);

        // Block still life
        do_clear;
        check("clear_alive", alive_count, 0);
        load_cell(0, 1'b1); load_cell(1, 1'b1); load_cell(8, 1'b1); load_cell(9, 1'b1);
        check("block_load_alive", alive_count, 4);
        pulse_step;
        wait_idle("block_idle");
        get_board(board);
        check("block_board", board, cells(0, 1, 8, 9, -1));
        check("block_stable", stable, 1);
        check("block_alive", alive_count, 4);
        check("block_gen", gen_count, 3);

        // Edge wrap on; wrap_en dropped mid-generation must not matter
        do_clear;
        load_cell(0, 1'b1); load_cell(8, 1'b1); load_cell(56, 1'b1);
        wrap_en = 1'b1;
        pulse_step;
        wrap_en = 1'b0;
        wait_idle("wrap1_idle");
        get_board(board);
        check("wrap1_board", board, cells(7, 0, 1, -1, -1));
        check("wrap1_alive", alive_count, 3);
        check("wrap1_stable", stable, 0);

        // Edge wrap off: everything dies
        do_clear;
        load_cell(0, 1'b1); load_cell(8, 1'b1); load_cell(56, 1'b1);
        pulse_step;
        wait_idle("wrap0_idle1");
        pulse_step;
        wait_idle("wrap0_idle2");
        get_board(board);
        check("wrap0_board", board, 0);
        check("wrap0_alive", alive_count, 0);
        check("wrap0_stable", stable, 1);
        check("wrap0_gen", gen_count, 6);

        // Glider under run + frame_tick, 32 generations returns to start
        reset = 1'b1; tick; reset = 1'b0;
        do_clear;
        load_cell(idx(0, 1, 3), 1'b1); load_cell(idx(1, 2, 3), 1'b1);
        load_cell(idx(2, 0, 3), 1'b1); load_cell(idx(2, 1, 3), 1'b1);
        load_cell(idx(2, 2, 3), 1'b1);
        wrap_en = 1'b1;
        run = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            repeat (499) tick;
            frame_tick = 1'b1; tick; frame_tick = 1'b0;
            if (k == 4) begin
                wait_idle("glider4_idle");
                get_board(board);
                check("glider4_board", board, cells(10, 19, 25, 26, 27));
            end
        end
        wait_idle("glider_idle");
        get_board(board);
        check("glider32_board", board, GLIDER_SEED_8X8);
        check("glider32_gen", gen_count, 32);
        check("glider32_alive", alive_count, 5);
        run = 1'b0;
        frame_tick = 1'b1; tick; frame_tick = 1'b0;
        check("norun_busy", busy, 0);
        repeat (100) tick;
        check("norun_gen", gen_count, 32);

        // Collisions during CALC: extra step, load and clear all ignored
        pulse_step;
        repeat (3) tick;
        step = 1'b1; tick; step = 1'b0;
        load_cell(5, 1'b1);
        do_clear;
        wait_idle("coll_idle");
        get_board(board);
        check("coll_board", board, cells(8, 10, 17, 18, 25));
        check("coll_gen", gen_count, 33);
        check("coll_alive", alive_count, 5);
        repeat (SIZE + 10) tick;
        check("coll_no_extra_gen", gen_count, 33);

        // Loads and clear in IDLE
        load_cell(5, 1'b1);
        rd_addr = 6'd5; #0.1;
        check("load5_rd", rd_data, 1);
        check("load5_alive", alive_count, 6);
        load_cell(5, 1'b1);
        check("reload5_alive", alive_count, 6);
        load_cell(8, 1'b0);
        check("kill8_alive", alive_count, 5);
        do_clear;
        check("clear2_alive", alive_count, 0);
        get_board(board);
        check("clear2_board", board, 0);

        // step and run&frame_tick together give one generation
        run = 1'b1; step = 1'b1; frame_tick = 1'b1;
        tick;
        run = 1'b0; step = 1'b0; frame_tick = 1'b0;
        wait_idle("dual_idle");
        repeat (SIZE + 10) tick;
        check("dual_gen", gen_count, 34);
        check("dual_stable", stable, 1);

        // Reset in the middle of CALC (i == 20)
        pulse_step;
        repeat (20) tick;
        check("midcalc_busy", busy, 1);
        reset = 1'b1;
        tick;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_gen", gen_count, 0);
        check("rst_mid_alive", alive_count, 3);
        get_board(board);
        check("rst_mid_board", board, BLINKER);
        reset = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
